// File: rtl/chan_bridge_pkg.sv
// Shared constants for the FX2 channel FIFO bridge: channel numbers,
// status/flush bit positions and the status byte packer.
package chan_bridge_pkg;

  localparam logic [6:0]  DEF_DATA_CHAN  = 7'd0;
  localparam logic [6:0]  DEF_STAT_CHAN  = 7'd1;
  localparam int unsigned DEF_DEPTH_LOG2 = 4;

  localparam int unsigned STAT_RXFULL  = 7;
  localparam int unsigned STAT_RXEMPTY = 6;
  localparam int unsigned STAT_TXFULL  = 5;
  localparam int unsigned STAT_TXEMPTY = 4;
  localparam int unsigned STAT_TXCNT_MSB = 3;
  localparam int unsigned STAT_TXCNT_LSB = 0;

  localparam int unsigned FLUSH_RX = 0;
  localparam int unsigned FLUSH_TX = 1;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_STAT,
    SEL_OTHER
  } chan_sel_e;

  function automatic logic [7:0] status_byte(input logic       rx_full,
                                             input logic       rx_empty,
                                             input logic       tx_full,
                                             input logic       tx_empty,
                                             input logic [3:0] tx_cnt);
    logic [7:0] s;
    s = '0;
    s[STAT_RXFULL]  = rx_full;
    s[STAT_RXEMPTY] = rx_empty;
    s[STAT_TXFULL]  = tx_full;
    s[STAT_TXEMPTY] = tx_empty;
    s[STAT_TXCNT_MSB:STAT_TXCNT_LSB] = tx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/chan_fifo_bridge_if.sv
// Host channel and application stream signals of the bridge, grouped.
// slave = bridge view, master = the surrounding comm module / application.
interface chan_fifo_bridge_if;
  logic [6:0] chanAddr_in;
  logic [7:0] h2fData_in;
  logic       h2fValid_in;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in;
  logic [7:0] appRxData_out;
  logic       appRxValid_out;
  logic       appRxReady_in;
  logic [7:0] appTxData_in;
  logic       appTxValid_in;
  logic       appTxReady_out;

  modport slave (
    input  chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
           appRxReady_in, appTxData_in, appTxValid_in,
    output h2fReady_out, f2hData_out, f2hValid_out,
           appRxData_out, appRxValid_out, appTxReady_out
  );

  modport master (
    output chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
           appRxReady_in, appTxData_in, appTxValid_in,
    input  h2fReady_out, f2hData_out, f2hValid_out,
           appRxData_out, appRxValid_out, appTxReady_out
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through byte FIFO with extra-MSB pointers, registered
// full/empty flags and a flush that drops everything currently queued.
module sync_fifo_fwft #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [7:0]          wdata_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic [7:0]          rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                push_ok, pop_ok;
  logic [7:0]          mem_q [DEPTH];

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Flush overrides a concurrent pop; a concurrent push survives the flush.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + PTR_ONE;
    if (flush_i)     rd_d = wr_q;
    else if (pop_ok) rd_d = rd_q + PTR_ONE;
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[DEPTH_LOG2] != rd_d[DEPTH_LOG2]) &&
              (wr_d[DEPTH_LOG2-1:0] == rd_d[DEPTH_LOG2-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_q ? '0 : mem_q[rd_q[DEPTH_LOG2-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/chan_fifo_bridge.sv
// Bridges the FX2 channel interface to an application byte stream via
// RX/TX FIFOs; a second channel gives status on read and flushes on write.
module chan_fifo_bridge
  import chan_bridge_pkg::*;
#(
  parameter logic [6:0]  DATA_CHAN  = DEF_DATA_CHAN,
  parameter logic [6:0]  STAT_CHAN  = DEF_STAT_CHAN,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic               clk_in,
  input  logic               reset_in,
  chan_fifo_bridge_if.slave  bus
);

  chan_sel_e           sel;
  logic                rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0]          rx_head, tx_head;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic [3:0]          tx_cnt_sat;

  always_comb begin
    sel = SEL_OTHER;
    if (bus.chanAddr_in == DATA_CHAN)      sel = SEL_DATA;
    else if (bus.chanAddr_in == STAT_CHAN) sel = SEL_STAT;
  end

  // Host writes off the data channel never stall; flush decodes only on STAT.
  assign bus.h2fReady_out = (sel == SEL_DATA) ? !rx_full : 1'b1;
  assign rx_push  = (sel == SEL_DATA) && bus.h2fValid_in && !rx_full;
  assign rx_flush = (sel == SEL_STAT) && bus.h2fValid_in && bus.h2fData_in[FLUSH_RX];
  assign tx_flush = (sel == SEL_STAT) && bus.h2fValid_in && bus.h2fData_in[FLUSH_TX];

  assign bus.appRxValid_out = !rx_empty;
  assign bus.appRxData_out  = rx_head;
  assign rx_pop = !rx_empty && bus.appRxReady_in;

  assign bus.appTxReady_out = !tx_full && !tx_flush;
  assign tx_push = bus.appTxValid_in && bus.appTxReady_out;
  assign tx_pop  = (sel == SEL_DATA) && !tx_empty && bus.f2hReady_in;

  always_comb begin
    tx_cnt_sat = 4'(tx_count);
    if (int'(tx_count) > 15) tx_cnt_sat = 4'hF;
  end

  always_comb begin
    bus.f2hValid_out = 1'b1;
    bus.f2hData_out  = '0;
    unique case (sel)
      SEL_DATA: begin
        bus.f2hValid_out = !tx_empty;
        bus.f2hData_out  = tx_head;
      end
      SEL_STAT:  bus.f2hData_out = status_byte(rx_full, rx_empty, tx_full, tx_empty, tx_cnt_sat);
      default:   bus.f2hData_out = '0;
    endcase
  end

  sync_fifo_fwft #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk_in),
    .rst     (reset_in),
    .push_i  (rx_push),
    .wdata_i (bus.h2fData_in),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  sync_fifo_fwft #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk_in),
    .rst     (reset_in),
    .push_i  (tx_push),
    .wdata_i (bus.appTxData_in),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  logic unused_rx_count;
  assign unused_rx_count = ^rx_count;

endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Scoreboard bench for chan_fifo_bridge: queues model both FIFOs, status
// bytes are rebuilt from queue depths, and directed scenarios hit the edges.
module tb_chan_fifo_bridge;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;

  chan_fifo_bridge_if bus();

  chan_fifo_bridge #(
    .DATA_CHAN  (7'd0),
    .STAT_CHAN  (7'd1),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stat_model(input int rxn, input int txn);
    logic [3:0] c;
    c = (txn > 15) ? 4'hF : 4'(txn);
    return {rxn == 16, rxn == 0, txn == 16, txn == 0, c};
  endfunction

  // One clock: settle inputs, check outputs against the model, account for
  // handshakes, then advance past the next rising edge.
  task automatic cycle();
    int rxn, txn;
    logic rx_fl, tx_fl;
    #1;
    if (reset_in) begin
      rx_q.delete();
      tx_q.delete();
    end else begin
      rxn = rx_q.size();
      txn = tx_q.size();
      rx_fl = (bus.chanAddr_in == 7'd1) && bus.h2fValid_in && bus.h2fData_in[0];
      tx_fl = (bus.chanAddr_in == 7'd1) && bus.h2fValid_in && bus.h2fData_in[1];

      chk("rx_valid", 8'(bus.appRxValid_out), 8'(rxn != 0));
      if (!bus.appRxValid_out) chk("rx_idle_data", bus.appRxData_out, 8'h00);
      if (bus.appRxValid_out && bus.appRxReady_in && rxn != 0)
        chk("rx_data", bus.appRxData_out, rx_q.pop_front());
      chk("tx_ready", 8'(bus.appTxReady_out), 8'(txn != 16 && !tx_fl));

      case (bus.chanAddr_in)
        7'd0: begin
          chk("h2f_ready", 8'(bus.h2fReady_out), 8'(rxn != 16));
          chk("f2h_valid", 8'(bus.f2hValid_out), 8'(txn != 0));
          if (!bus.f2hValid_out) chk("f2h_idle_data", bus.f2hData_out, 8'h00);
          if (bus.f2hValid_out && bus.f2hReady_in && txn != 0)
            chk("f2h_data", bus.f2hData_out, tx_q.pop_front());
          if (bus.h2fValid_in && bus.h2fReady_out) rx_q.push_back(bus.h2fData_in);
        end
        7'd1: begin
          chk("stat_ready", 8'(bus.h2fReady_out), 8'h01);
          chk("stat_valid", 8'(bus.f2hValid_out), 8'h01);
          chk("status", bus.f2hData_out, stat_model(rxn, txn));
        end
        default: begin
          chk("other_ready", 8'(bus.h2fReady_out), 8'h01);
          chk("other_valid", 8'(bus.f2hValid_out), 8'h01);
          chk("other_data", bus.f2hData_out, 8'h00);
        end
      endcase

      if (bus.appTxValid_in && bus.appTxReady_out) tx_q.push_back(bus.appTxData_in);
      if (rx_fl) rx_q.delete();
      if (tx_fl) tx_q.delete();
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.h2fValid_in   = 1'b0;
    bus.h2fData_in    = '0;
    bus.f2hReady_in   = 1'b0;
    bus.appRxReady_in = 1'b0;
    bus.appTxValid_in = 1'b0;
    bus.appTxData_in  = '0;
  endtask

  initial begin
    logic [7:0] seq3 [3];
    seq3[0] = 8'h11; seq3[1] = 8'h22; seq3[2] = 8'h33;
    bus.chanAddr_in = 7'd0;
    idle_inputs();
    repeat (2) @(posedge clk_in);
    #1;
    reset_in = 1'b0;

    // Reset state on each kind of address
    #1;
    chk("rst_h2f_ready", 8'(bus.h2fReady_out), 8'h01);
    chk("rst_f2h_valid", 8'(bus.f2hValid_out), 8'h00);
    chk("rst_rx_valid", 8'(bus.appRxValid_out), 8'h00);
    chk("rst_rx_data", bus.appRxData_out, 8'h00);
    chk("rst_tx_ready", 8'(bus.appTxReady_out), 8'h01);
    bus.chanAddr_in = 7'd1;
    #1 chk("rst_status", bus.f2hData_out, 8'h50);
    bus.chanAddr_in = 7'd9;
    #1 chk("rst_other_valid", 8'(bus.f2hValid_out), 8'h01);
    cycle();
    bus.chanAddr_in = 7'd0;
    cycle();

    // Back-to-back host writes streamed straight through to the app
    bus.appRxReady_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.h2fValid_in = 1'b1;
      bus.h2fData_in  = seq3[i];
      if (i == 1) begin
        #1;
        chk("rx_latency", 8'(bus.appRxValid_out), 8'h01);
        chk("rx_first", bus.appRxData_out, 8'h11);
      end
      cycle();
    end
    bus.h2fValid_in = 1'b0;
    repeat (3) cycle();

    // Fill RX to 16, 17th stalls until one pop has registered
    bus.appRxReady_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.h2fValid_in = 1'b1;
      bus.h2fData_in  = 8'(8'h40 + i);
      cycle();
    end
    bus.h2fData_in = 8'h5A;
    #1 chk("rx_full_ready", 8'(bus.h2fReady_out), 8'h00);
    cycle();
    bus.h2fValid_in = 1'b0;
    bus.chanAddr_in = 7'd1;
    #1 chk("stat_rx_full", bus.f2hData_out, 8'h90);
    cycle();
    bus.chanAddr_in   = 7'd0;
    bus.h2fValid_in   = 1'b1;
    bus.appRxReady_in = 1'b1;
    cycle();
    bus.appRxReady_in = 1'b0;
    #1 chk("rx_17th_ready", 8'(bus.h2fReady_out), 8'h01);
    cycle();
    bus.h2fValid_in   = 1'b0;
    bus.appRxReady_in = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() != 0; i++) cycle();
    #1 chk("rx_drained", 8'(bus.appRxValid_out), 8'h00);
    bus.appRxReady_in = 1'b0;
    cycle();

    // App fills five TX bytes, status read then host drains data channel
    bus.chanAddr_in   = 7'd1;
    bus.appTxValid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.appTxData_in = 8'(8'hA0 + i);
      cycle();
    end
    bus.appTxValid_in = 1'b0;
    #1 chk("stat_tx5", bus.f2hData_out, 8'h45);
    cycle();
    bus.chanAddr_in = 7'd0;
    bus.f2hReady_in = 1'b1;
    repeat (5) cycle();
    #1;
    chk("tx_empty_valid", 8'(bus.f2hValid_out), 8'h00);
    chk("tx_empty_data", bus.f2hData_out, 8'h00);
    bus.f2hReady_in = 1'b0;
    cycle();

    // RX flush wins over a concurrent app pop
    bus.h2fValid_in = 1'b1;
    bus.h2fData_in  = 8'h61;
    cycle();
    bus.h2fData_in  = 8'h62;
    cycle();
    bus.chanAddr_in   = 7'd1;
    bus.h2fData_in    = 8'h01;
    bus.appRxReady_in = 1'b1;
    cycle();
    bus.h2fValid_in   = 1'b0;
    bus.appRxReady_in = 1'b0;
    #1 chk("rx_flushed", 8'(bus.appRxValid_out), 8'h00);
    cycle();

    // TX flush blocks the concurrent app push, which lands next cycle
    bus.appTxValid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.appTxData_in = 8'(8'hB0 + i);
      cycle();
    end
    bus.appTxData_in = 8'hC0;
    bus.h2fValid_in  = 1'b1;
    bus.h2fData_in   = 8'h02;
    #1 chk("flush_tx_block", 8'(bus.appTxReady_out), 8'h00);
    cycle();
    bus.h2fValid_in = 1'b0;
    #1;
    chk("stat_tx_flushed", bus.f2hData_out, 8'h50);
    chk("flush_tx_ready", 8'(bus.appTxReady_out), 8'h01);
    cycle();
    bus.appTxValid_in = 1'b0;
    bus.chanAddr_in   = 7'd0;
    #1 chk("tx_after_flush", bus.f2hData_out, 8'hC0);
    bus.f2hReady_in = 1'b1;
    cycle();
    bus.f2hReady_in = 1'b0;
    cycle();

    // Mid-stream reset with both FIFOs partly loaded and bytes in flight
    for (int i = 0; i < 7; i++) begin
      bus.h2fValid_in   = (i < 5);
      bus.h2fData_in    = 8'(8'h70 + i);
      bus.appTxValid_in = 1'b1;
      bus.appTxData_in  = 8'(8'h80 + i);
      cycle();
    end
    reset_in = 1'b1;
    cycle();
    reset_in = 1'b0;
    idle_inputs();
    #1;
    chk("rst2_rx_valid", 8'(bus.appRxValid_out), 8'h00);
    chk("rst2_f2h_valid", 8'(bus.f2hValid_out), 8'h00);
    bus.chanAddr_in = 7'd1;
    #1 chk("rst2_status", bus.f2hData_out, 8'h50);
    bus.chanAddr_in = 7'd0;

    // 40 concurrent push/pop pairs to wrap both pointer sets
    bus.appRxReady_in = 1'b1;
    bus.f2hReady_in   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.h2fValid_in   = 1'b1;
      bus.h2fData_in    = 8'($urandom_range(0, 255));
      bus.appTxValid_in = 1'b1;
      bus.appTxData_in  = 8'($urandom_range(0, 255));
      cycle();
    end
    bus.h2fValid_in   = 1'b0;
    bus.appTxValid_in = 1'b0;
    repeat (4) cycle();
    #1;
    chk("final_rx_valid", 8'(bus.appRxValid_out), 8'h00);
    chk("final_f2h_valid", 8'(bus.f2hValid_out), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/chan_fifo_bridge.md
# chan_fifo_bridge

Buffering stage between the FX2 comm module's channel interface (chanAddr/h2f/f2h) and an application core. Host writes to a configurable data channel are queued in an RX FIFO and presented to the application as a ready/valid byte stream. Application bytes are queued in a TX FIFO and returned on host reads of the same channel. A second channel provides a status byte on read and flush commands on write.

## Interface
- DATA_CHAN, 7'd0, channel address carrying stream data in both directions
- STAT_CHAN, 7'd1, channel address for status reads and flush writes
- DEPTH_LOG2, 4, log2 of entries per FIFO (16); legal range 2..8

- clk_in  input  1  single clock (48 MHz FX2 clock); all state changes on the rising edge
- reset_in  input  1  synchronous, active-high reset
- chanAddr_in  input  7  currently selected channel
- h2fData_in  input  8  host-to-FPGA byte
- h2fValid_in  input  1  host byte offered this cycle
- h2fReady_out  output  1  bridge accepts the host byte this cycle
- f2hData_out  output  8  FPGA-to-host byte
- f2hValid_out  output  1  f2hData_out is valid
- f2hReady_in  input  1  host consumes f2hData_out this cycle
- appRxData_out  output  8  RX FIFO head byte to the application
- appRxValid_out  output  1  RX FIFO not empty
- appRxReady_in  input  1  application pops the RX head
- appTxData_in  input  8  application byte for the host
- appTxValid_in  input  1  application byte offered
- appTxReady_out  output  1  TX FIFO accepts the byte this cycle

## Operation
- Two identical first-word-fall-through FIFOs, RX and TX, each with 2^DEPTH_LOG2 entries. Each FIFO uses DEPTH_LOG2+1-bit read and write pointers.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Count = wr − rd, modulo 2^(DEPTH_LOG2+1).
- RX push: chanAddr_in==DATA_CHAN && h2fValid_in && h2fReady_out.
  - h2fReady_out = !rxFull when addr==DATA_CHAN; otherwise 1.
  - Writes to any address other than DATA_CHAN and STAT_CHAN are accepted and discarded.
- RX pop: appRxValid_out && appRxReady_in. appRxValid_out = !rxEmpty. appRxData_out = RX head, or 8'h00 when empty.
- TX push: appTxValid_in && appTxReady_out. appTxReady_out = !txFull && !txFlushNow.
- TX pop: chanAddr_in==DATA_CHAN && f2hValid_out && f2hReady_in.
- f2h mux by chanAddr_in:
  - DATA_CHAN: valid = !txEmpty, data = TX head.
  - STAT_CHAN: valid = 1, data = {rxFull, rxEmpty, txFull, txEmpty, txCountSat[3:0]}, where txCountSat = min(txCount, 15).
  - Any other address: valid = 1, data = 8'h00.
  - f2hData_out = 8'h00 whenever f2hValid_out = 0.
- Flush: a write to STAT_CHAN (h2fValid_in, ready is always 1) issues flush commands.
  - h2fData_in[0] flushes RX: rd pointer ← wr pointer.
  - h2fData_in[1] flushes TX (txFlushNow, combinational from chanAddr_in, h2fValid_in and h2fData_in[1]).
  - Other bits are ignored.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both take effect; count unchanged.
  - Push while full: impossible, because ready is low. Ready uses the registered full flag, with no same-cycle pop bypass.
  - Pop while empty: impossible, because valid is low.
  - RX flush with a concurrent app pop: flush wins.
  - TX flush: concurrent app push is blocked by appTxReady_out = 0; a concurrent host pop cannot occur because the address differs.
- Reset (including mid-transfer): all pointers go to 0; both FIFOs are empty; storage contents are not cleared. Outputs after reset:
  - appRxValid_out=0, appRxData_out=0, appTxReady_out=1, h2fReady_out=1.
  - f2hValid_out=0 if addr==DATA_CHAN, else 1.
  - In-flight bytes are lost.

## Timing
- Pointers and flags are registered. All handshake outputs are combinational from registered flags plus chanAddr_in; h2fData_in feeds only the flush path.
- Latency:
  - Host byte accepted at edge N → appRxValid_out high after edge N, usable at edge N+1.
  - App byte accepted at edge N → f2hValid_out high after N when DATA_CHAN is selected.
- Throughput: one byte per cycle in each direction concurrently.
- Status byte reflects state as of the last edge. A flush is visible in status on the cycle after the write.

## Structure
- Shared package/include chan_bridge_pkg:
  - Default channel numbers.
  - Status bit positions: STAT_RXFULL=7, STAT_RXEMPTY=6, STAT_TXFULL=5, STAT_TXEMPTY=4, STAT_TXCNT=3:0.
  - Flush bit positions: FLUSH_RX=0, FLUSH_TX=1.
- One sub-module, sync_fifo_fwft: parameter DEPTH_LOG2, width 8, ports for push/pop/flush/full/empty/count. It is instantiated twice; the top holds the address decode and muxing.

## Test plan
- Reset then idle, addr=0: h2fReady_out=1, f2hValid_out=0, appRxValid_out=0, appTxReady_out=1. Addr=1 gives f2hData_out=8'h50.
- Host writes 0x11,0x22,0x33 to ch0 back-to-back with appRxReady_in=1 → app sees 0x11,0x22,0x33 on consecutive cycles, starting one cycle after the first accept.
- Host writes 17 bytes to ch0 with appRxReady_in=0 → 16 accepted, h2fReady_out=0 on the 17th. Status reads 8'h90 after the app pre-loads nothing. One app pop → the 17th byte is accepted next cycle.
- App pushes 0xA0..0xA4, then the host reads ch1 then ch0 → status 8'h45; ch0 reads 0xA0..0xA4, then f2hValid_out=0 with data 0x00.
- With TX holding 3 bytes and appTxValid_in=1, the host writes 0x02 to ch1 → appTxReady_out=0 that cycle. The next cycle's status is 8'h50 (TX empty), and the app byte is accepted on the following cycle.
- Mid-stream reset (RX 5 bytes, TX 7 bytes) → next cycle both empty, status 8'h50, and pointer wrap is verified by 40 subsequent push/pop pairs with data intact.
